// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral: frame geometry, mode and FSM states.
package spi_pkg;

    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
    // Mode 0: CPOL=0, CPHA=0 (sample on sclk rise, change on sclk fall).
    localparam int unsigned SPI_MODE   = 0;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } spi_state_e;

endpackage

// File: rtl/spi_peripheral_if.sv
// Bus-side signals of the SPI peripheral: the SPI pins plus the tx/rx byte handshake.
interface spi_peripheral_if;

    logic                            i_sclk;
    logic                            i_cs_n;
    logic                            i_copi;
    logic                            o_cipo;
    logic [spi_pkg::FRAME_BITS-1:0]  i_tx;
    logic                            i_tx_valid;
    logic                            o_tx_ready;
    logic [spi_pkg::FRAME_BITS-1:0]  o_rx;
    logic                            o_rx_valid;
    logic                            o_busy;
    logic                            o_error;

    // The peripheral side.
    modport slave (
        input  i_sclk, i_cs_n, i_copi, i_tx, i_tx_valid,
        output o_cipo, o_tx_ready, o_rx, o_rx_valid, o_busy, o_error
    );

    // The controller / host side.
    modport master (
        output i_sclk, i_cs_n, i_copi, i_tx, i_tx_valid,
        input  o_cipo, o_tx_ready, o_rx, o_rx_valid, o_busy, o_error
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer followed by an edge register producing rise/fall strobes.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Shift the pin through the synchronizer and remember the previous settled value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
            prev_q <= sync_s;
        end
    end

    assign o_rise = sync_s & ~prev_q;
    assign o_fall = ~sync_s & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral, MSB first, 8-bit frames, with a one-byte tx holding register.
// Optional: define SPI_PERIPHERAL_ERR_EN to pulse o_error on tx underrun or aborted frame.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    spi_peripheral_if.slave  bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (bus.i_sclk),
        .o_rise (sclk_rise),
        .o_fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (bus.i_cs_n),
        .o_rise (cs_rise),
        .o_fall (cs_fall)
    );

    // copi needs no edge detection, only the same delay as sclk so the two stay aligned.
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic                   copi_s;
    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    spi_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  reload_pend_q, reload_pend_d;
    logic                  rx_done_q, rx_done_d;
    logic [FRAME_BITS-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [FRAME_BITS-1:0] rx_q;
    logic                  rx_valid_q;
    logic                  reload;

    // FSM and shift datapath next-state.
    always_comb begin
        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        bit_cnt_d     = bit_cnt_q;
        reload_pend_d = reload_pend_q;
        rx_done_d     = 1'b0;
        reload        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) state_d = StLoad;
            end
            StLoad: begin
                state_d = StShift;
                reload  = 1'b1;
            end
            StShift: begin
                if (cs_rise) begin
                    // A partial byte is dropped; a completed one was already handed off.
                    state_d       = StIdle;
                    rx_shift_d    = '0;
                    bit_cnt_d     = '0;
                    reload_pend_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], copi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        rx_done_d     = 1'b1;
                        reload_pend_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    // The fall after the last bit starts the next byte instead of shifting.
                    if (reload_pend_q) begin
                        reload        = 1'b1;
                        reload_pend_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (reload) tx_shift_d = hold_full_q ? hold_q : '0;
    end

    // Holding register: a reload reads the pre-write contents, a same-cycle write is kept.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (reload) hold_full_d = 1'b0;
        if (bus.i_tx_valid && !hold_full_q) begin
            hold_d      = bus.i_tx;
            hold_full_d = 1'b1;
        end
    end

    // State registers, copi synchronizer and the registered rx output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            copi_sync_q   <= '0;
            state_q       <= StIdle;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            reload_pend_q <= 1'b0;
            rx_done_q     <= 1'b0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            rx_q          <= '0;
            rx_valid_q    <= 1'b0;
        end else begin
            copi_sync_q   <= {copi_sync_q[SYNC_STAGES-2:0], bus.i_copi};
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            bit_cnt_q     <= bit_cnt_d;
            reload_pend_q <= reload_pend_d;
            rx_done_q     <= rx_done_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rx_valid_q    <= rx_done_q;
            if (rx_done_q) rx_q <= rx_shift_q;
        end
    end

    assign bus.o_cipo     = (state_q != StIdle) && tx_shift_q[FRAME_BITS-1];
    assign bus.o_busy     = (state_q != StIdle);
    assign bus.o_tx_ready = !hold_full_q;
    assign bus.o_rx       = rx_q;
    assign bus.o_rx_valid = rx_valid_q;

`ifdef SPI_PERIPHERAL_ERR_EN
    logic abort;
    logic err_q;
    assign abort = (state_q == StShift) && cs_rise && (bit_cnt_q != '0);

    // One-cycle error pulse on an empty-holding reload or a frame cut mid-byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (reload && !hold_full_q) || abort;
        end
    end

    assign bus.o_error = err_q;
`else
    assign bus.o_error = 1'b0;
`endif

endmodule
